round_timer: RTL and testbench

- Parametrised round/timeout timer for the GENIUS game controller; successor to the fixed 0..9 time counter.
- Counts prescaled ticks from 0 up to a runtime-loaded limit and pulses end_time on expiry.
- Supports one-shot and auto-reload modes, pause via enable, and abort.
- Exposes a remaining-count output for the display path.

---
 rtl/timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/round_timer.sv | 75 +++++++
 tb/tb_round_timer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the round/timeout timer.
// Holds the FSM state enum and the MODE encodings used by round_timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler producing one tick every PRE_DIV enabled cycles.
// Ports: CLKT clock, R async reset, clear sync clear, enable, tick.
module tick_prescaler #(
    parameter int PRE_DIV = 1
) (
    input  logic CLKT,
    input  logic R,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    logic [PW-1:0] cnt;

    // With PRE_DIV=1 the terminal value is 0 and cnt never leaves 0,
    // so tick degenerates to enable.
    assign tick = enable && (cnt == PW'(PRE_DIV - 1));

    always_ff @(posedge CLKT or posedge R) begin
        if (R) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/round_timer.sv
// Round/timeout timer: counts prescaled ticks from 0 to a loaded limit.
// Ports: CLKT, R, E, START, ABORT, MODE, LIMIT in; TEMPO, REMAIN,
//        end_time, BUSY, EXPIRED out.
module round_timer
    import timer_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int PRE_DIV = 1
) (
    input  logic            CLKT,
    input  logic            R,
    input  logic            E,
    input  logic            START,
    input  logic            ABORT,
    input  logic            MODE,
    input  logic [SIZE-1:0] LIMIT,
    output logic [SIZE-1:0] TEMPO,
    output logic [SIZE-1:0] REMAIN,
    output logic            end_time,
    output logic            BUSY,
    output logic            EXPIRED
);

    state_t          state;
    logic [SIZE-1:0] lim_q;
    logic            mode_q;
    logic            tick;

    tick_prescaler #(
        .PRE_DIV(PRE_DIV)
    ) u_pre (
        .CLKT  (CLKT),
        .R     (R),
        .clear (START | ABORT),
        .enable((state == RUN) && E),
        .tick  (tick)
    );

    // TEMPO never passes lim_q, so the difference cannot go negative.
    assign REMAIN  = lim_q - TEMPO;
    assign BUSY    = (state == RUN);
    assign EXPIRED = (state == DONE);

    always_ff @(posedge CLKT or posedge R) begin
        if (R) begin
            state    <= IDLE;
            TEMPO    <= '0;
            lim_q    <= '0;
            mode_q   <= MODE_ONESHOT;
            end_time <= 1'b0;
        end else begin
            end_time <= 1'b0;
            if (ABORT) begin
                TEMPO <= '0;
                state <= IDLE;
            end else if (START) begin
                lim_q  <= LIMIT;
                mode_q <= MODE;
                TEMPO  <= '0;
                state  <= RUN;
            end else if (tick) begin
                if (TEMPO != lim_q) begin
                    TEMPO <= TEMPO + SIZE'(1);
                end else begin
                    TEMPO    <= '0;
                    end_time <= 1'b1;
                    if (mode_q != MODE_RELOAD) begin
                        state <= DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer (PRE_DIV=1 and PRE_DIV=4 instances).
// Directed scenarios with literal checks, then randomized stimulus.
module tb_round_timer;

    logic       clk;
    logic       r;
    logic       e;
    logic       start;
    logic       abort;
    logic       mode;
    logic [3:0] limit;

    logic [3:0] tempo1, remain1, tempo4, remain4;
    logic       et1, busy1, exp1, et4, busy4, exp4;

    int checks = 0;
    int errors = 0;

    round_timer #(.SIZE(4), .PRE_DIV(1)) dut1 (
        .CLKT(clk), .R(r), .E(e), .START(start), .ABORT(abort),
        .MODE(mode), .LIMIT(limit), .TEMPO(tempo1), .REMAIN(remain1),
        .end_time(et1), .BUSY(busy1), .EXPIRED(exp1)
    );

    round_timer #(.SIZE(4), .PRE_DIV(4)) dut4 (
        .CLKT(clk), .R(r), .E(e), .START(start), .ABORT(abort),
        .MODE(mode), .LIMIT(limit), .TEMPO(tempo4), .REMAIN(remain4),
        .end_time(et4), .BUSY(busy4), .EXPIRED(exp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 run, 2 done; n counts enabled run cycles
    // since start or last expiry.
    typedef struct {
        int ph;
        int lim;
        bit mode;
        int n;
        bit et;
    } mdl_t;

    mdl_t m1, m4;

    function automatic mdl_t step(mdl_t m, int pd);
        mdl_t x = m;
        x.et = 1'b0;
        if (abort) begin
            x.ph = 0;
            x.n  = 0;
        end else if (start) begin
            x.ph   = 1;
            x.lim  = int'(limit);
            x.mode = mode;
            x.n    = 0;
        end else if (m.ph == 1 && e) begin
            x.n = m.n + 1;
            if (x.n == pd * (m.lim + 1)) begin
                x.et = 1'b1;
                x.n  = 0;
                if (!m.mode) x.ph = 2;
            end
        end
        return x;
    endfunction

    function automatic int mtempo(mdl_t m, int pd);
        return (m.ph == 1) ? m.n / pd : 0;
    endfunction

    always @(posedge clk or posedge r) begin
        if (r) begin
            m1 <= '{ph: 0, lim: 0, mode: 1'b0, n: 0, et: 1'b0};
            m4 <= '{ph: 0, lim: 0, mode: 1'b0, n: 0, et: 1'b0};
        end else begin
            m1 <= step(m1, 1);
            m4 <= step(m4, 4);
        end
    end

    task automatic chk(string name, logic [31:0] act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic cmp_all();
        int t1, t4;
        t1 = mtempo(m1, 1);
        t4 = mtempo(m4, 4);
        chk("m1.tempo", 32'(tempo1), t1);
        chk("m1.remain", 32'(remain1), m1.lim - t1);
        chk("m1.end_time", 32'(et1), int'(m1.et));
        chk("m1.busy", 32'(busy1), int'(m1.ph == 1));
        chk("m1.expired", 32'(exp1), int'(m1.ph == 2));
        chk("m4.tempo", 32'(tempo4), t4);
        chk("m4.remain", 32'(remain4), m4.lim - t4);
        chk("m4.end_time", 32'(et4), int'(m4.et));
        chk("m4.busy", 32'(busy4), int'(m4.ph == 1));
        chk("m4.expired", 32'(exp4), int'(m4.ph == 2));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic start_run(int lim, bit md);
        limit = 4'(lim);
        mode  = md;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        r = 1'b1; e = 1'b0; start = 1'b0; abort = 1'b0;
        mode = 1'b0; limit = 4'd0;
        #2;
        chk("rst.tempo", 32'(tempo1), 0);
        chk("rst.end_time", 32'(et1), 0);
        chk("rst.busy", 32'(busy1), 0);
        chk("rst.expired", 32'(exp4), 0);
        #10 r = 1'b0;
        e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle.tempo", 32'(tempo1), 0);
        end

        // One-shot, LIMIT=9
        start_run(9, 1'b0);
        chk("os.busy", 32'(busy1), 1);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("os.tempo", 32'(tempo1), k);
            chk("os.et_low", 32'(et1), 0);
        end
        cyc();
        chk("os.end_time", 32'(et1), 1);
        chk("os.tempo0", 32'(tempo1), 0);
        chk("os.expired", 32'(exp1), 1);
        chk("os.busy0", 32'(busy1), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("os.hold", 32'(tempo1), 0);
        end

        // Auto-reload, LIMIT=2, PRE_DIV=4
        start_run(2, 1'b1);
        chk("rl.remain0", 32'(remain4), 2);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (i == 12 || i == 24) chk("rl.end_time", 32'(et4), 1);
            if (i == 4) chk("rl.remain1", 32'(remain4), 1);
            if (i == 8) chk("rl.remain2", 32'(remain4), 0);
            if (i == 5) chk("rl.tempo", 32'(tempo4), 1);
        end
        chk("rl.busy", 32'(busy4), 1);

        // Pause at TEMPO=5 for 7 cycles
        start_run(9, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        chk("pz.tempo5", 32'(tempo1), 5);
        e = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("pz.hold", 32'(tempo1), 5);
        end
        e = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("pz.et_early", 32'(et1), 0);
        cyc();
        chk("pz.end_time", 32'(et1), 1);

        // ABORT on the expiring edge
        start_run(9, 1'b0);
        for (int i = 0; i < 9; i++) cyc();
        chk("ab.tempo9", 32'(tempo1), 9);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab.end_time", 32'(et1), 0);
        chk("ab.tempo", 32'(tempo1), 0);
        chk("ab.busy", 32'(busy1), 0);
        chk("ab.expired", 32'(exp1), 0);

        // Restart mid-count with a new LIMIT
        start_run(9, 1'b0);
        for (int i = 0; i < 6; i++) cyc();
        chk("rs.tempo6", 32'(tempo1), 6);
        start_run(3, 1'b0);
        chk("rs.tempo0", 32'(tempo1), 0);
        chk("rs.remain", 32'(remain1), 3);
        for (int i = 0; i < 3; i++) cyc();
        cyc();
        chk("rs.end_time", 32'(et1), 1);

        // Async reset while end_time is high in RUN
        start_run(1, 1'b1);
        cyc();
        cyc();
        chk("ar.et_pre", 32'(et1), 1);
        chk("ar.busy_pre", 32'(busy1), 1);
        #2 r = 1'b1;
        #1;
        chk("ar.end_time", 32'(et1), 0);
        chk("ar.busy", 32'(busy1), 0);
        chk("ar.tempo4", 32'(tempo4), 0);
        chk("ar.busy4", 32'(busy4), 0);
        chk("ar.remain", 32'(remain1), 0);
        #1 r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ar.idle", 32'(tempo1), 0);
            chk("ar.idle_busy", 32'(busy1), 0);
        end

        // LIMIT=0 and LIMIT=15
        start_run(0, 1'b0);
        cyc();
        chk("l0.end_time", 32'(et1), 1);
        start_run(15, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("l15.tempo", 32'(tempo1), k);
        end
        cyc();
        chk("l15.end_time", 32'(et1), 1);
        chk("l15.tempo0", 32'(tempo1), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            e     = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 24) == 0);
            abort = ($urandom_range(0, 59) == 0);
            mode  = 1'($urandom_range(0, 1));
            limit = 4'($urandom_range(0, 15));
            cyc();
        end
        start = 1'b0;
        abort = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
